// File: rtl/p02_simon_autoplayer.sv
// rtl/p02_simon_autoplayer.sv - Simon autoplayer: records the shown LED sequence and replays it on the buttons
// Optional feature macro: AUTOPLAY_MISTAKE_EN (adds input miss; the last replayed step presses the next colour)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ticks_per_milli   clk cycles per millisecond (0 behaves as 1)
//   en                autoplay enable; low returns to IDLE and clears the sequence
//   miss              (AUTOPLAY_MISTAKE_EN only) deliberately get the last step wrong
//   led               game LED bus, one-hot or zero
//   btn               button drive, one-hot or zero
//   busy              high while replaying (PRESS/RELEASE)
//   seq_len           number of recorded entries
//   error             sticky: non-one-hot LED or buffer overflow
module p02_simon_autoplayer #(
  parameter int MAX_LEN    = 32,
  parameter int GAP_MS     = 400,
  parameter int PRESS_MS   = 150,
  parameter int RELEASE_MS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  input  logic        en,
`ifdef AUTOPLAY_MISTAKE_EN
  input  logic        miss,
`endif
  input  logic [3:0]  led,
  output logic [3:0]  btn,
  output logic        busy,
  output logic [5:0]  seq_len,
  output logic        error
);

  localparam int          AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [5:0]  MAX_LEN_W  = 6'(MAX_LEN);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [15:0] GAP_W      = 16'(GAP_MS);
  localparam logic [15:0] PRESS_LAST = 16'(PRESS_MS - 1);
  localparam logic [15:0] REL_LAST   = 16'(RELEASE_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LISTEN, S_PRESS, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;       // ms prescaler
  logic [15:0] ms_q, ms_d;         // elapsed ms inside PRESS/RELEASE
  logic [15:0] gap_q, gap_d;       // dark ms in LISTEN
  logic [3:0]  led_q, led_d;
  logic        pend_q, pend_d;     // rising edge seen last cycle, entry written now
  logic [3:0]  pend_led_q, pend_led_d;
  logic [5:0]  rd_q, rd_d;
  logic [5:0]  seq_q, seq_d;
  logic [3:0]  btn_q, btn_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [1:0]  mem_q [MAX_LEN];
  logic        mem_we;
  logic [AW-1:0] mem_wa;
  logic [1:0]  mem_wd;

  logic [15:0] tpm_last;
  logic        ms_tick;
  logic [5:0]  load_ptr;
  logic [1:0]  load_idx;
  logic [3:0]  load_btn;

  // Button pattern for the step about to be pressed: step 0 when leaving
  // LISTEN, rd_ptr+1 when leaving RELEASE.
  always_comb begin
    load_ptr = (state_q == S_RELEASE) ? rd_q + 6'd1 : 6'd0;
    load_idx = mem_q[load_ptr[AW-1:0]];
`ifdef AUTOPLAY_MISTAKE_EN
    if (miss && (load_ptr == seq_q - 6'd1)) load_idx = load_idx + 2'd1;
`endif
    load_btn = 4'b0001 << load_idx;
  end

  always_comb begin
    tpm_last = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    // >= keeps the prescaler sane if ticks_per_milli shrinks at run time
    ms_tick  = (cnt_q >= tpm_last);

    state_d    = state_q;
    cnt_d      = ms_tick ? 16'd0 : cnt_q + 16'd1;
    ms_d       = ms_q;
    gap_d      = gap_q;
    led_d      = led;
    pend_d     = 1'b0;
    pend_led_d = pend_led_q;
    rd_d       = rd_q;
    seq_d      = seq_q;
    btn_d      = btn_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wa     = seq_q[AW-1:0];
    mem_wd     = {pend_led_q[3] | pend_led_q[2], pend_led_q[3] | pend_led_q[1]};

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        ms_d  = 16'd0;
        gap_d = 16'd0;
        rd_d  = 6'd0;
        seq_d = 6'd0;
        btn_d = 4'd0;
        if (en) state_d = S_LISTEN;
      end
      S_LISTEN: begin
        btn_d      = 4'd0;
        pend_d     = (led_q == 4'd0) && (led != 4'd0);
        pend_led_d = led;
        if (pend_q) begin
          if (!$onehot(pend_led_q) || (seq_q == MAX_LEN_W)) err_d = 1'b1;
          else begin
            mem_we = 1'b1;
            seq_d  = seq_q + 6'd1;
          end
        end
        if (led != 4'd0) begin
          gap_d = 16'd0;
          if (led != led_q) cnt_d = 16'd0;
        end else if (led_q != 4'd0) begin
          cnt_d = 16'd0;  // LED just went dark: gap timing starts on a fresh ms grid
        end else if (ms_tick) begin
          if ((seq_q != 6'd0) && (gap_q == GAP_LAST)) begin
            state_d = S_PRESS;
            ms_d    = 16'd0;
            rd_d    = 6'd0;
            btn_d   = load_btn;
          end else if (gap_q != GAP_W) begin
            gap_d = gap_q + 16'd1;  // saturates while nothing is recorded
          end
        end
      end
      S_PRESS: begin
        if (ms_tick) begin
          if (ms_q == PRESS_LAST) begin
            state_d = S_RELEASE;
            ms_d    = 16'd0;
            btn_d   = 4'd0;
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end
      end
      S_RELEASE: begin
        if (ms_tick) begin
          if (ms_q == REL_LAST) begin
            ms_d = 16'd0;
            rd_d = rd_q + 6'd1;
            if (rd_q + 6'd1 == seq_q) begin
              state_d = S_LISTEN;
              seq_d   = 6'd0;
              gap_d   = 16'd0;
            end else begin
              state_d = S_PRESS;
              btn_d   = load_btn;
            end
          end else begin
            ms_d = ms_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
      btn_d   = 4'd0;
      seq_d   = 6'd0;
      pend_d  = 1'b0;
      mem_we  = 1'b0;
    end

    busy_d = (state_d == S_PRESS) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      ms_q       <= 16'd0;
      gap_q      <= 16'd0;
      led_q      <= 4'd0;
      pend_q     <= 1'b0;
      pend_led_q <= 4'd0;
      rd_q       <= 6'd0;
      seq_q      <= 6'd0;
      btn_q      <= 4'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ms_q       <= ms_d;
      gap_q      <= gap_d;
      led_q      <= led_d;
      pend_q     <= pend_d;
      pend_led_q <= pend_led_d;
      rd_q       <= rd_d;
      seq_q      <= seq_d;
      btn_q      <= btn_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign btn     = btn_q;
  assign busy    = busy_q;
  assign seq_len = seq_q;
  assign error   = err_q;

endmodule

// File: tb/tb_p02_simon_autoplayer.sv
// tb/tb_p02_simon_autoplayer.sv - directed self-checking bench for p02_simon_autoplayer
module tb_p02_simon_autoplayer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm;
  logic        en;
`ifdef AUTOPLAY_MISTAKE_EN
  logic        miss;
`endif
  logic [3:0]  led;
  logic [3:0]  btn;
  logic        busy;
  logic [5:0]  seq_len;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  p02_simon_autoplayer #(
    .MAX_LEN   (32),
    .GAP_MS    (4),
    .PRESS_MS  (2),
    .RELEASE_MS(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ticks_per_milli(tpm),
    .en             (en),
`ifdef AUTOPLAY_MISTAKE_EN
    .miss           (miss),
`endif
    .led            (led),
    .btn            (btn),
    .busy           (busy),
    .seq_len        (seq_len),
    .error          (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Light v for on_cyc cycles, then dark for off_cyc cycles (led left at 0).
  task automatic show(input logic [3:0] v, input int on_cyc, input int off_cyc);
    led = v;
    repeat (on_cyc) tick();
    led = 4'd0;
    repeat (off_cyc) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; led = 4'd0; tpm = 16'd4;
    tick(); tick();
    vectors++; if (btn !== 4'd0) begin miscompares++; $display("FAIL reset_btn got %b want 0000", btn); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL reset_seq_len got %0d want 0", seq_len); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error); end
    rst = 1'b0;
    tick();
  endtask

  // Cycle c counts edges after led was driven dark; the edge after that drive
  // is the first to sample dark, then the 4 ms gap spans 16 cycles.
  task automatic test_replay();
    logic [3:0] exp_btn [3];
    logic [3:0] want_btn;
    logic       want_busy;
    int         p;
    exp_btn = '{4'b0010, 4'b1000, 4'b0001};
    en = 1'b1;
    tick();
    show(4'b0010, 12, 4);
    show(4'b1000, 12, 4);
    show(4'b0001, 12, 0);
    vectors++; if (seq_len !== 6'd3) begin miscompares++; $display("FAIL replay_seq_len got %0d want 3", seq_len); end
    for (int c = 1; c <= 56; c++) begin
      tick();
      if (c >= 17 && c <= 52) begin
        p = c - 17;
        want_btn  = (p % 12 < 8) ? exp_btn[p / 12] : 4'b0000;
        want_busy = 1'b1;
      end else begin
        want_btn  = 4'b0000;
        want_busy = 1'b0;
      end
      vectors++; if (btn !== want_btn) begin miscompares++; $display("FAIL replay_btn cycle %0d got %b want %b", c, btn, want_btn); end
      vectors++; if (busy !== want_busy) begin miscompares++; $display("FAIL replay_busy cycle %0d got %b want %b", c, busy, want_busy); end
    end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL replay_seq_after got %0d want 0", seq_len); end
  endtask

  task automatic test_error();
    logic [3:0] want_btn;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL error_before got %b want 0", error); end
    led = 4'b0011;
    tick(); tick();
    led = 4'd0;
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_set got %b want 1", error); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL error_seq_len got %0d want 0", seq_len); end
    tick(); tick();
    show(4'b0100, 12, 0);
    vectors++; if (seq_len !== 6'd1) begin miscompares++; $display("FAIL error_valid_seq got %0d want 1", seq_len); end
    for (int c = 1; c <= 32; c++) begin
      tick();
      want_btn = (c >= 17 && c <= 24) ? 4'b0100 : 4'b0000;
      vectors++; if (btn !== want_btn) begin miscompares++; $display("FAIL error_replay_btn cycle %0d got %b want %b", c, btn, want_btn); end
    end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL error_sticky got %b want 1", error); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL error_seq_after got %0d want 0", seq_len); end
  endtask

  task automatic test_overflow();
    logic [3:0] want_btn;
    logic [3:0] prev_btn;
    int         p;
    int         steps;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL ovf_error_cleared got %b want 0", error); end
    tick();
    for (int i = 0; i < 33; i++) begin
      led = 4'b0001 << (i % 4);
      tick(); tick();
      led = 4'd0;
      if (i == 31) begin
        vectors++; if (seq_len !== 6'd32) begin miscompares++; $display("FAIL ovf_full_seq got %0d want 32", seq_len); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL ovf_full_error got %b want 0", error); end
      end
      if (i < 32) begin tick(); tick(); end
    end
    vectors++; if (seq_len !== 6'd32) begin miscompares++; $display("FAIL ovf_seq_hold got %0d want 32", seq_len); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL ovf_error got %b want 1", error); end
    steps = 0;
    prev_btn = 4'd0;
    for (int c = 1; c <= 404; c++) begin
      tick();
      if (c >= 17 && c <= 400) begin
        p = c - 17;
        want_btn = (p % 12 < 8) ? (4'b0001 << ((p / 12) % 4)) : 4'b0000;
      end else begin
        want_btn = 4'b0000;
      end
      vectors++; if (btn !== want_btn) begin miscompares++; $display("FAIL ovf_replay_btn cycle %0d got %b want %b", c, btn, want_btn); end
      if (btn != 4'd0 && prev_btn == 4'd0) steps++;
      prev_btn = btn;
    end
    vectors++; if (steps !== 32) begin miscompares++; $display("FAIL ovf_steps got %0d want 32", steps); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL ovf_seq_after got %0d want 0", seq_len); end
  endtask

  task automatic test_en_drop();
    logic [3:0] want_btn;
    int         stray;
    show(4'b0001, 12, 4);
    show(4'b0010, 12, 4);
    show(4'b0100, 12, 0);
    for (int c = 1; c <= 38; c++) begin
      tick();
      if (c >= 17 && c <= 24)      want_btn = 4'b0001;
      else if (c >= 29 && c <= 36) want_btn = 4'b0010;
      else                         want_btn = 4'b0000;
      vectors++; if (btn !== want_btn) begin miscompares++; $display("FAIL endrop_btn cycle %0d got %b want %b", c, btn, want_btn); end
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL endrop_busy_release got %b want 1", busy); end
    en = 1'b0;
    tick();
    vectors++; if (btn !== 4'd0) begin miscompares++; $display("FAIL endrop_btn_next got %b want 0000", btn); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL endrop_seq_next got %0d want 0", seq_len); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL endrop_busy_next got %b want 0", busy); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL endrop_error_kept got %b want 1", error); end
    stray = 0;
    repeat (30) begin
      tick();
      if (btn != 4'd0) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL endrop_stray_presses got %0d want 0", stray); end
  endtask

  task automatic test_reset_mid_press();
    en = 1'b1;
    tick();
    show(4'b1000, 12, 0);
    repeat (17) tick();
    vectors++; if (btn !== 4'b1000) begin miscompares++; $display("FAIL rmp_press got %b want 1000", btn); end
    tick(); tick();
    rst = 1'b1;
    tick();
    vectors++; if (btn !== 4'd0) begin miscompares++; $display("FAIL rmp_btn got %b want 0000", btn); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmp_busy got %b want 0", busy); end
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL rmp_seq got %0d want 0", seq_len); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rmp_error got %b want 0", error); end
    rst = 1'b0;
    tick();
    led = 4'b0001;
    tick();
    vectors++; if (seq_len !== 6'd0) begin miscompares++; $display("FAIL rmp_latency1 got %0d want 0", seq_len); end
    tick();
    vectors++; if (seq_len !== 6'd1) begin miscompares++; $display("FAIL rmp_latency2 got %0d want 1", seq_len); end
    led = 4'd0;
    en = 1'b0;
    tick();
  endtask

`ifdef AUTOPLAY_MISTAKE_EN
  task automatic test_mistake();
    logic [3:0] want_btn;
    miss = 1'b1;
    en = 1'b1;
    tick();
    show(4'b0001, 12, 4);
    show(4'b0100, 12, 0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c >= 17 && c <= 24)      want_btn = 4'b0001;
      else if (c >= 29 && c <= 36) want_btn = 4'b1000;
      else                         want_btn = 4'b0000;
      vectors++; if (btn !== want_btn) begin miscompares++; $display("FAIL mistake_btn cycle %0d got %b want %b", c, btn, want_btn); end
    end
    miss = 1'b0;
  endtask
`endif

  initial begin
`ifdef AUTOPLAY_MISTAKE_EN
    miss = 1'b0;
`endif
    test_reset();
    test_replay();
    test_error();
    test_overflow();
    test_en_drop();
    test_reset_mid_press();
`ifdef AUTOPLAY_MISTAKE_EN
    test_mistake();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/p02_simon_autoplayer.md
# p02_simon_autoplayer

Automatic player for the Simon game core: watches the four game LEDs during the game's "show" phase, records the colour sequence, then replays it on the four button lines with fixed press/release timing. It sits beside `p02_simon` in the same Tiny Tapeout project. Its `btn` outputs are ORed with the pad buttons by the parent, and its `led` input taps the core's LED bus. It is the responder end of the game's LED→button protocol, used for self-test and demo mode.

## Interface
- `MAX_LEN`, 32: sequence buffer depth (entries of 2 bits).
- `GAP_MS`, 400: LED-dark time in ms that ends a show phase.
- `PRESS_MS`, 150: button hold time in ms per replayed step.
- `RELEASE_MS`, 100: button-released time in ms after each step.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ticks_per_milli`  in  16  clk cycles per millisecond; 0 is treated as 1.
- `en`  in  1  autoplay enable; low forces IDLE.
- `led`  in  4  game LED bus, one-hot or zero.
- `btn`  out  4  button drive, one-hot or zero.
- `busy`  out  1  high in PRESS/RELEASE.
- `seq_len`  out  6  number of valid recorded entries.
- `error`  out  1  sticky: non-one-hot LED seen or buffer overflow.

## Operation
- Prescaler: counter restarts at 0 on every state entry and on every LED change in LISTEN. It emits `ms_tick` when it reaches `ticks_per_milli-1`, then wraps. A phase of N ms lasts exactly N*ticks_per_milli cycles.
- `led_q` is a 1-cycle registered copy of `led`. A rising edge is `led_q==0 && led!=0`.
- States:
  - IDLE: `btn=0`, buffer length 0. Go to LISTEN when `en=1`.
  - LISTEN: on a rising edge with one-hot `led`, write index (0..3) at `wr_ptr` and increment `seq_len`. A rising edge with non-one-hot `led` sets `error` and records nothing.
  - LISTEN gap count: counts ms while `led==0`; any nonzero `led` clears the count. When `seq_len>0` and the count reaches `GAP_MS`, set `rd_ptr=0` and go to PRESS.
  - PRESS: `btn = 1<<buf[rd_ptr]` for `PRESS_MS`, then go to RELEASE.
  - RELEASE: `btn=0` for `RELEASE_MS`, then `rd_ptr++`. If `rd_ptr==seq_len`, clear `seq_len` to 0 and go to LISTEN. Otherwise go to PRESS.
- `led` is ignored in PRESS and RELEASE, because the game echoes presses on its LEDs.
- Overflow: a rising edge with `seq_len==MAX_LEN` is dropped and sets `error`; `seq_len` holds at `MAX_LEN`.
- `en` low in any state: next cycle goes to IDLE, `btn=0`, `seq_len=0`; `error` is kept.
- `rst`: next edge sets all registers to reset values, mid-replay included.

## Timing
- Reset values: `btn=0`, `busy=0`, `seq_len=0`, `error=0`, state IDLE, prescaler 0.
- Record latency: `seq_len` increments on the second clock edge after `led` goes nonzero (edge 1 registers `led_q`, edge 2 writes the entry).
- The first `btn` assertion follows the edge on which the gap count reaches `GAP_MS`. All outputs are registered, so there is no combinational path from `led` to `btn`.
- `busy` is asserted in the same cycles as the PRESS/RELEASE states.
- A replay of length L lasts exactly `L*(PRESS_MS+RELEASE_MS)*ticks_per_milli` cycles.

## Configuration
- `AUTOPLAY_MISTAKE_EN`, when defined:
  - Adds input port `miss` (1 bit), sampled on entry to PRESS for the step where `rd_ptr==seq_len-1`.
  - If `miss=1`, that last step presses `(index+1) mod 4` instead of `index`, to test the game's failure path.
- When not defined: the port is absent and replay is always exact.

## Test plan
Parameters for all scenarios: `ticks_per_milli=4`, `GAP_MS=4`, `PRESS_MS=2`, `RELEASE_MS=1`.
- Reset mid-PRESS: all outputs are 0 the next cycle and the state is IDLE. With `en=1`, the block is back in LISTEN one cycle after reset deasserts.
- Show LEDs 0010, 1000, 0001 (3 ms each, 1 ms dark between), then dark:
  - `seq_len` reads 3.
  - 16 cycles after the last LED falls, `btn` drives 0010, 1000, 0001, each for 8 cycles, separated by 4 zero cycles.
  - `seq_len` reads 0 afterwards.
- `led=0011` pulse in LISTEN: `error=1`, `seq_len` unchanged. The error persists after the next valid replay.
- Drive 33 valid LED pulses: `seq_len=32`, `error=1`, and the replay has 32 steps.
- Drop `en` during RELEASE of step 2: `btn=0` and `seq_len=0` the next cycle, no further presses.
- With `AUTOPLAY_MISTAKE_EN` and `miss=1`, recorded sequence 0,2: replay presses 0001 then 1000.
